mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage placed directly downstream of `ex`. It consumes the ALU result (used as the effective address), load/store flags, `funct3` and store data. It runs a request/acknowledge transaction on the data-memory port, aligns and sign-extends load data, generates store byte masks, and detects misaligned and timed-out accesses. While a transaction is outstanding it stalls the pipeline through `mem_not_ready_o`, in the same way `ex` stalls through `div_not_ready_o`.

## Interface
- `TIMEOUT`, default 64: REQ cycles without `dmem_ack_i` before an access fault is raised.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `load_i`, `store_i`  in  1 each  access type from EX; never both high.
- `funct3_i`  in  3  access size and signedness.
- `aluout_i`  in  64  effective address for loads and stores; result value otherwise.
- `sdata_i`  in  64  store data.
- `wen_i`, `rd_i`  in  1, 5  register writeback request.
- `csr_wen_i`, `csr_addr_i`, `csr_wdata_i`  in  1, 12, 64  CSR write; passed through.
- `exception_i`, `mcause_i`, `pc_i`  in  1, 64, 64  exception from upstream.
- `dmem_req_o`  out  1  bus request.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  64  doubleword-aligned address, `{aluout_i[63:3], 3'b0}`.
- `dmem_wdata_o`  out  64  lane-replicated store data.
- `dmem_wmask_o`  out  8  byte enables.
- `dmem_ack_i`  in  1  access complete.
- `dmem_rdata_i`  in  64  read doubleword, valid when `dmem_ack_i` is high.
- `wen_o`, `rd_o`, `wdata_o`  out  1, 5, 64  writeback to WB.
- `csr_wen_o`, `csr_addr_o`, `csr_wdata_o`  out  passthrough.
- `exception_o`, `mcause_o`, `pc_o`, `mtval_o`  out  1, 64, 64, 64  exception to WB; `mtval_o` carries the faulting address.
- `mem_not_ready_o`  out  1  stall request; EX/MEM inputs are held stable while it is high.

## Operation
- Access needed: `(load_i | store_i) & ~exception_i`.
- Upstream exception (`exception_i` high): no bus activity; exception, `mcause`, `pc` and `wen_i` pass through unchanged.
- Misaligned access (checked combinationally in IDLE):
  - Conditions: half with `addr[0]`; word with `addr[1:0] != 0`; double with `addr[2:0] != 0`.
  - Response: no request, no stall, `exception_o=1`, `wen_o=0`, `csr_wen_o=0`, `mtval_o=aluout_i`.
  - `mcause_o` = 4 for a load, 6 for a store.
- FSM states:
  - IDLE: if an aligned access is needed, assert `mem_not_ready_o` and go to REQ. Otherwise pass through with no stall.
  - REQ: `dmem_req_o=1` with addr/we/wdata/mask stable; timeout counter increments each cycle.
    - `dmem_ack_i` high: capture `dmem_rdata_i`, go to DONE.
    - Counter reaches `TIMEOUT` with no ack: flag fault, go to DONE.
    - Ack and timeout in the same cycle: ack wins.
  - DONE: `mem_not_ready_o=0` and outputs are driven from the captured data or fault. The pipeline advances; return to IDLE.
- Load extraction, byte lane `off = addr[2:0]`:
  - 000 lb and 100 lbu: byte at `off`, sign- or zero-extended.
  - 001 lh and 101 lhu: half at `off`.
  - 010 lw and 110 lwu: word at `off`.
  - 011 ld: full doubleword.
  - 111 is treated as ld.
- Store masks and data:
  - sb: mask `8'h01<<off`, data = byte ×8.
  - sh: mask `8'h03<<off`, data = half ×4.
  - sw: mask `8'h0F<<off`, data = word ×2.
  - sd: mask `8'hFF`, data unchanged.
- `wdata_o` = extracted load data for loads, otherwise `aluout_i`. Stores force `wen_o=0`.
- Fault in DONE: `exception_o=1`, `wen_o=0`; `mcause_o` = 5 for a load, 7 for a store.
- While `mem_not_ready_o` is high, `wen_o`, `csr_wen_o` and `exception_o` are forced to 0.

## Timing
- Reset values: state IDLE, all `dmem_*_o` 0, timeout counter 0, captured data 0, `mem_not_ready_o` 0. Passthrough outputs follow their inputs.
- `dmem_req_o` is registered: it rises one cycle after the access enters IDLE and falls in the cycle after ack is sampled.
- Minimum access with ack on the first REQ cycle: 3 cycles (IDLE, REQ, DONE), of which 2 are stalled.
- Timed-out access: exactly `TIMEOUT` REQ cycles, then DONE.
- `dmem_ack_i` is ignored outside REQ.
- Reset asserted mid-access: `dmem_req_o` drops asynchronously and the FSM returns to IDLE. No partial result is written back.
- Back-to-back accesses: the next access enters IDLE in the cycle after DONE. Minimum spacing between requests is 3 cycles.

## Structure
- Add to `define.v`:
  - funct3 load/store codes.
  - mcause codes `EXC_LD_MISALIGN`=4, `EXC_LD_FAULT`=5, `EXC_ST_MISALIGN`=6, `EXC_ST_FAULT`=7.
  - FSM state encodings.
  - `SEXT` is reused.
- One combinational sub-module, `load_align`: lane select plus sign/zero extension (`rdata`, `off`, `funct3` → 64-bit result).
- Store mask/replication generation and the FSM stay in `mem_access`.

## Test plan
- Load extension: lb at 0x1003, rdata 0x0000_0000_8000_0000, ack on the first REQ cycle → `wdata_o`=0xFFFF_FFFF_FFFF_FF80. lbu of the same → 0x80. Stall high exactly 2 cycles.
- Store lanes: sh at 0x2006, `sdata_i`=0xABCD → `dmem_addr_o`=0x2000, mask 0xC0, `dmem_wdata_o`=0xABCD_ABCD_ABCD_ABCD, `dmem_we_o`=1, `wen_o`=0.
- Misaligned load: lw at 0x3002 → `dmem_req_o` never rises, no stall, `exception_o`=1, `mcause_o`=4, `mtval_o`=0x3002, `wen_o`=0.
- Timeout: `TIMEOUT`=4, ld at 0x4000, ack never arrives → 4 REQ cycles, then `mcause_o`=5 and `exception_o`=1 in DONE. A second run with ack on the 4th cycle gets valid data and no fault.
- Reset mid-access: reset asserted in REQ → `dmem_req_o`=0 immediately. After release, an ALU op with `aluout_i`=0x55 gives `wdata_o`=0x55, `mem_not_ready_o`=0.
- Passthrough: `exception_i`=1, `mcause_i`=2 with `load_i`=1 → no request, no stall, outputs `mcause_o`=2.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, trap causes,
// FSM states and small helpers used by the stage and its load aligner.
package mem_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [63:0] EXC_LD_MISALIGN = 64'd4;
    localparam logic [63:0] EXC_LD_FAULT    = 64'd5;
    localparam logic [63:0] EXC_ST_MISALIGN = 64'd6;
    localparam logic [63:0] EXC_ST_FAULT    = 64'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    // Sign-extend the low byte/half/word of val; size 2'b11 returns val unchanged.
    function automatic logic [63:0] sext(input logic [63:0] val, input logic [1:0] size);
        case (size)
            2'b00:   return {{56{val[7]}},  val[7:0]};
            2'b01:   return {{48{val[15]}}, val[15:0]};
            2'b10:   return {{32{val[31]}}, val[31:0]};
            default: return val;
        endcase
    endfunction

    // Natural alignment check; funct3[1:0] alone selects the access size.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] off);
        case (funct3[1:0])
            2'b01:   return off[0];
            2'b10:   return off[1:0] != 2'b00;
            2'b11:   return off != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load aligner: selects the addressed lane of a read doubleword and
// sign- or zero-extends it according to funct3.
module load_align
    import mem_access_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] result
);

    logic [63:0] lane;

    always_comb begin
        lane   = rdata >> {off, 3'b000};
        result = rdata;
        case (funct3)
            F3_LB, F3_LH, F3_LW: result = sext(lane, funct3[1:0]);
            F3_LBU:              result = {56'b0, lane[7:0]};
            F3_LHU:              result = {48'b0, lane[15:0]};
            F3_LWU:              result = {32'b0, lane[31:0]};
            default:             result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: drives a req/ack data-memory transaction, stalls the
// pipeline while it is outstanding, and reports misaligned or timed-out accesses.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] aluout_i,
    input  logic [63:0] sdata_i,
    input  logic        wen_i,
    input  logic [4:0]  rd_i,
    input  logic        csr_wen_i,
    input  logic [11:0] csr_addr_i,
    input  logic [63:0] csr_wdata_i,
    input  logic        exception_i,
    input  logic [63:0] mcause_i,
    input  logic [63:0] pc_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    output logic [7:0]  dmem_wmask_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        wen_o,
    output logic [4:0]  rd_o,
    output logic [63:0] wdata_o,
    output logic        csr_wen_o,
    output logic [11:0] csr_addr_o,
    output logic [63:0] csr_wdata_o,
    output logic        exception_o,
    output logic [63:0] mcause_o,
    output logic [63:0] pc_o,
    output logic [63:0] mtval_o,
    output logic        mem_not_ready_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [63:0]   rdata_q;
    logic          fault;

    logic          need, misalign, start, mem_fault, mem_exc;
    logic [7:0]    st_mask;
    logic [63:0]   st_data, load_data;

    assign need      = (load_i | store_i) & ~exception_i;
    assign misalign  = (state == ST_IDLE) & need & misaligned(funct3_i, aluout_i[2:0]);
    assign start     = (state == ST_IDLE) & need & ~misaligned(funct3_i, aluout_i[2:0]);
    assign mem_fault = (state == ST_DONE) & fault;
    assign mem_exc   = misalign | mem_fault;

    always_comb begin
        st_mask = 8'hFF;
        st_data = sdata_i;
        case (funct3_i[1:0])
            2'b00: begin st_mask = 8'h01 << aluout_i[2:0]; st_data = {8{sdata_i[7:0]}};  end
            2'b01: begin st_mask = 8'h03 << aluout_i[2:0]; st_data = {4{sdata_i[15:0]}}; end
            2'b10: begin st_mask = 8'h0F << aluout_i[2:0]; st_data = {2{sdata_i[31:0]}}; end
            default: ;
        endcase
    end

    // Bus outputs are registered; reset drops the request immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_wmask_o <= '0;
            cnt          <= '0;
            rdata_q      <= '0;
            fault        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    fault <= 1'b0;
                    if (start) begin
                        state        <= ST_REQ;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= store_i;
                        dmem_addr_o  <= {aluout_i[63:3], 3'b000};
                        dmem_wdata_o <= store_i ? st_data : '0;
                        dmem_wmask_o <= store_i ? st_mask : '0;
                        cnt          <= '0;
                    end
                end
                ST_REQ: begin
                    if (dmem_ack_i || cnt == CW'(TIMEOUT - 1)) begin
                        state        <= ST_DONE;
                        dmem_req_o   <= 1'b0;
                        dmem_we_o    <= 1'b0;
                        dmem_wdata_o <= '0;
                        dmem_wmask_o <= '0;
                        fault        <= ~dmem_ack_i;
                        if (dmem_ack_i) rdata_q <= dmem_rdata_i;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    load_align u_load_align (
        .rdata  (rdata_q),
        .off    (aluout_i[2:0]),
        .funct3 (funct3_i),
        .result (load_data)
    );

    assign mem_not_ready_o = start | (state == ST_REQ);

    always_comb begin
        mcause_o = mcause_i;
        if (misalign)       mcause_o = load_i ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
        else if (mem_fault) mcause_o = load_i ? EXC_LD_FAULT : EXC_ST_FAULT;
    end

    assign exception_o = ~mem_not_ready_o & (exception_i | mem_exc);
    assign wen_o       = ~mem_not_ready_o & ~mem_exc & wen_i & (exception_i | ~store_i);
    assign csr_wen_o   = ~mem_not_ready_o & ~mem_exc & csr_wen_i;
    assign wdata_o     = (load_i & ~exception_i) ? load_data : aluout_i;
    assign mtval_o     = mem_exc ? aluout_i : '0;
    assign rd_o        = rd_i;
    assign csr_addr_o  = csr_addr_i;
    assign csr_wdata_o = csr_wdata_i;
    assign pc_o        = pc_i;

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access with TIMEOUT=4 and a scripted memory responder.
module tb_mem_access;

    logic        clock, reset;
    logic        load_i, store_i;
    logic [2:0]  funct3_i;
    logic [63:0] aluout_i, sdata_i;
    logic        wen_i;
    logic [4:0]  rd_i;
    logic        csr_wen_i;
    logic [11:0] csr_addr_i;
    logic [63:0] csr_wdata_i;
    logic        exception_i;
    logic [63:0] mcause_i, pc_i;
    logic        dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_wmask_o;
    logic        dmem_ack_i;
    logic [63:0] dmem_rdata_i;
    logic        wen_o;
    logic [4:0]  rd_o;
    logic [63:0] wdata_o;
    logic        csr_wen_o;
    logic [11:0] csr_addr_o;
    logic [63:0] csr_wdata_o;
    logic        exception_o;
    logic [63:0] mcause_o, pc_o, mtval_o;
    logic        mem_not_ready_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          stalls, reqs, first_req_cyc;
    bit          leak, tmo;
    logic        r_we;
    logic [63:0] r_addr, r_wdata;
    logic [7:0]  r_mask;

    mem_access #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
        .aluout_i(aluout_i), .sdata_i(sdata_i),
        .wen_i(wen_i), .rd_i(rd_i),
        .csr_wen_i(csr_wen_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .exception_i(exception_i), .mcause_i(mcause_i), .pc_i(pc_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .wen_o(wen_o), .rd_o(rd_o), .wdata_o(wdata_o),
        .csr_wen_o(csr_wen_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .exception_o(exception_o), .mcause_o(mcause_o), .pc_o(pc_o), .mtval_o(mtval_o),
        .mem_not_ready_o(mem_not_ready_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic set_idle();
        load_i = 0; store_i = 0; funct3_i = 3'b000; aluout_i = '0; sdata_i = '0;
        wen_i = 0; rd_i = '0; csr_wen_i = 0; csr_addr_i = 12'h305; csr_wdata_i = 64'h1234;
        exception_i = 0; mcause_i = '0; pc_i = 64'h8000_0000;
        dmem_ack_i = 0; dmem_rdata_i = '0;
    endtask

    task automatic set_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] sd);
        load_i = ld; store_i = st; funct3_i = f3; aluout_i = addr; sdata_i = sd;
        wen_i = 1; rd_i = 5'd7; csr_wen_i = 1; exception_i = 0;
    endtask

    task automatic idle_cycle();
        set_idle();
        @(posedge clock); #1;
    endtask

    // Enter in IDLE at posedge+1 with an access applied; leaves in DONE at posedge+2.
    // ack_on = n acknowledges on the n-th REQ cycle, 0 never acknowledges.
    task automatic run_access(input int ack_on, input logic [63:0] rd);
        stalls = 0; reqs = 0; leak = 0; tmo = 1; first_req_cyc = -1;
        r_we = 0; r_addr = '0; r_wdata = '0; r_mask = '0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!mem_not_ready_o) begin tmo = 0; break; end
            stalls++;
            if (wen_o || exception_o || csr_wen_o) leak = 1;
            if (dmem_req_o) begin
                if (reqs == 0) begin
                    r_we = dmem_we_o; r_addr = dmem_addr_o; r_wdata = dmem_wdata_o;
                    r_mask = dmem_wmask_o; first_req_cyc = cyc;
                end
                reqs++;
                if (reqs == ack_on) begin dmem_ack_i = 1; dmem_rdata_i = rd; end
            end
            @(posedge clock); #1;
            dmem_ack_i = 0; dmem_rdata_i = '0;
        end
        checks++;
        if (tmo) begin failures++; $display("FAIL access_bound stall never cleared"); end
    endtask

    task automatic test_reset();
        reset = 0; set_idle(); aluout_i = 64'h77; wen_i = 1; rd_i = 5'd3;
        #2;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", dmem_req_o); end
        checks++; if ({dmem_we_o, dmem_wmask_o, dmem_addr_o, dmem_wdata_o} !== '0) begin failures++; $display("FAIL rst_bus got nonzero bus outputs"); end
        checks++; if (mem_not_ready_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", mem_not_ready_o); end
        checks++; if (wdata_o !== 64'h77 || wen_o !== 1'b1 || rd_o !== 5'd3) begin failures++; $display("FAIL rst_pass wdata=%h wen=%b rd=%0d exp 77/1/3", wdata_o, wen_o, rd_o); end
        @(negedge clock); reset = 1;
        @(posedge clock); #1;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3 [8];
        logic [63:0] ad [8];
        logic [63:0] rv [8];
        logic [63:0] ex [8];
        f3[0] = 3'b000; ad[0] = 64'h1003; rv[0] = 64'h0000_0000_8000_0000; ex[0] = 64'hFFFF_FFFF_FFFF_FF80;
        f3[1] = 3'b100; ad[1] = 64'h1003; rv[1] = 64'h0000_0000_8000_0000; ex[1] = 64'h0000_0000_0000_0080;
        f3[2] = 3'b001; ad[2] = 64'h1006; rv[2] = 64'h8001_2345_6789_ABCD; ex[2] = 64'hFFFF_FFFF_FFFF_8001;
        f3[3] = 3'b101; ad[3] = 64'h1002; rv[3] = 64'h8001_2345_6789_ABCD; ex[3] = 64'h0000_0000_0000_6789;
        f3[4] = 3'b010; ad[4] = 64'h1004; rv[4] = 64'h8001_2345_6789_ABCD; ex[4] = 64'hFFFF_FFFF_8001_2345;
        f3[5] = 3'b110; ad[5] = 64'h1000; rv[5] = 64'h8001_2345_6789_ABCD; ex[5] = 64'h0000_0000_6789_ABCD;
        f3[6] = 3'b011; ad[6] = 64'h1008; rv[6] = 64'h8001_2345_6789_ABCD; ex[6] = 64'h8001_2345_6789_ABCD;
        f3[7] = 3'b111; ad[7] = 64'h1010; rv[7] = 64'hFEDC_BA98_7654_3210; ex[7] = 64'hFEDC_BA98_7654_3210;
        for (int i = 0; i < 8; i++) begin
            set_access(1, 0, f3[i], ad[i], '0);
            run_access(1, rv[i]);
            checks++; if (stalls != 2 || reqs != 1) begin failures++; $display("FAIL load%0d_timing stalls=%0d reqs=%0d exp 2/1", i, stalls, reqs); end
            checks++; if (r_addr !== {ad[i][63:3], 3'b000} || r_we !== 1'b0) begin failures++; $display("FAIL load%0d_bus addr=%h we=%b", i, r_addr, r_we); end
            checks++; if (leak) begin failures++; $display("FAIL load%0d_leak got=1 exp=0", i); end
            checks++; if (wdata_o !== ex[i]) begin failures++; $display("FAIL load%0d_data got=%h exp=%h", i, wdata_o, ex[i]); end
            checks++; if (wen_o !== 1'b1 || exception_o !== 1'b0 || csr_wen_o !== 1'b1 || dmem_req_o !== 1'b0) begin failures++; $display("FAIL load%0d_done wen=%b exc=%b csr=%b req=%b", i, wen_o, exception_o, csr_wen_o, dmem_req_o); end
            idle_cycle();
        end
    endtask

    task automatic test_store_lanes();
        logic [2:0]  f3 [4];
        logic [63:0] ad [4];
        logic [63:0] sd [4];
        logic [63:0] ed [4];
        logic [7:0]  em [4];
        f3[0] = 3'b001; ad[0] = 64'h2006; sd[0] = 64'hABCD;                ed[0] = 64'hABCD_ABCD_ABCD_ABCD; em[0] = 8'hC0;
        f3[1] = 3'b000; ad[1] = 64'h2005; sd[1] = 64'h1234_5678_9ABC_DE5A; ed[1] = 64'h5A5A_5A5A_5A5A_5A5A; em[1] = 8'h20;
        f3[2] = 3'b010; ad[2] = 64'h2004; sd[2] = 64'h1122_3344_DEAD_BEEF; ed[2] = 64'hDEAD_BEEF_DEAD_BEEF; em[2] = 8'hF0;
        f3[3] = 3'b011; ad[3] = 64'h2008; sd[3] = 64'h0102_0304_0506_0708; ed[3] = 64'h0102_0304_0506_0708; em[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            set_access(0, 1, f3[i], ad[i], sd[i]);
            run_access(1, '0);
            checks++; if (r_addr !== {ad[i][63:3], 3'b000} || r_we !== 1'b1) begin failures++; $display("FAIL store%0d_addr addr=%h we=%b", i, r_addr, r_we); end
            checks++; if (r_mask !== em[i]) begin failures++; $display("FAIL store%0d_mask got=%h exp=%h", i, r_mask, em[i]); end
            checks++; if (r_wdata !== ed[i]) begin failures++; $display("FAIL store%0d_wdata got=%h exp=%h", i, r_wdata, ed[i]); end
            checks++; if (wen_o !== 1'b0 || exception_o !== 1'b0 || stalls != 2) begin failures++; $display("FAIL store%0d_done wen=%b exc=%b stalls=%0d", i, wen_o, exception_o, stalls); end
            idle_cycle();
        end
    endtask

    task automatic test_misaligned();
        set_access(1, 0, 3'b010, 64'h3002, '0);
        #1;
        checks++; if (mem_not_ready_o !== 1'b0 || exception_o !== 1'b1) begin failures++; $display("FAIL mis_ld stall=%b exc=%b exp 0/1", mem_not_ready_o, exception_o); end
        checks++; if (mcause_o !== 64'd4 || mtval_o !== 64'h3002 || wen_o !== 1'b0 || csr_wen_o !== 1'b0) begin failures++; $display("FAIL mis_ld_info mcause=%0d mtval=%h wen=%b csr=%b", mcause_o, mtval_o, wen_o, csr_wen_o); end
        @(posedge clock); #1;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL mis_ld_req got=%b exp=0", dmem_req_o); end
        set_access(0, 1, 3'b011, 64'h3004, 64'h99);
        #1;
        checks++; if (mcause_o !== 64'd6 || exception_o !== 1'b1 || mem_not_ready_o !== 1'b0) begin failures++; $display("FAIL mis_sd mcause=%0d exc=%b stall=%b", mcause_o, exception_o, mem_not_ready_o); end
        set_access(0, 1, 3'b001, 64'h3001, 64'h99);
        #1;
        checks++; if (mcause_o !== 64'd6 || mtval_o !== 64'h3001) begin failures++; $display("FAIL mis_sh mcause=%0d mtval=%h", mcause_o, mtval_o); end
        @(posedge clock); #1;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL mis_st_req got=%b exp=0", dmem_req_o); end
        idle_cycle();
    endtask

    task automatic test_timeout();
        set_access(1, 0, 3'b011, 64'h4000, '0);
        run_access(0, '0);
        checks++; if (reqs != 4 || stalls != 5) begin failures++; $display("FAIL tmo_ld_cycles reqs=%0d stalls=%0d exp 4/5", reqs, stalls); end
        checks++; if (exception_o !== 1'b1 || mcause_o !== 64'd5 || mtval_o !== 64'h4000 || wen_o !== 1'b0) begin failures++; $display("FAIL tmo_ld_fault exc=%b mcause=%0d mtval=%h wen=%b", exception_o, mcause_o, mtval_o, wen_o); end
        idle_cycle();
        set_access(0, 1, 3'b011, 64'h4008, 64'h5);
        run_access(0, '0);
        checks++; if (exception_o !== 1'b1 || mcause_o !== 64'd7 || reqs != 4) begin failures++; $display("FAIL tmo_st_fault exc=%b mcause=%0d reqs=%0d", exception_o, mcause_o, reqs); end
        idle_cycle();
        set_access(1, 0, 3'b011, 64'h4000, '0);
        run_access(4, 64'hCAFE_F00D_1234_5678);
        checks++; if (reqs != 4 || exception_o !== 1'b0 || wen_o !== 1'b1) begin failures++; $display("FAIL tmo_ack4 reqs=%0d exc=%b wen=%b", reqs, exception_o, wen_o); end
        checks++; if (wdata_o !== 64'hCAFE_F00D_1234_5678) begin failures++; $display("FAIL tmo_ack4_data got=%h", wdata_o); end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        set_access(1, 0, 3'b011, 64'h4000, '0);
        @(posedge clock); #1;
        checks++; if (dmem_req_o !== 1'b1) begin failures++; $display("FAIL rmid_req_up got=%b exp=1", dmem_req_o); end
        #1 reset = 0;
        #1;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL rmid_req_drop got=%b exp=0", dmem_req_o); end
        set_idle(); aluout_i = 64'h55; wen_i = 1;
        @(negedge clock); reset = 1;
        @(posedge clock); #1;
        checks++; if (wdata_o !== 64'h55 || mem_not_ready_o !== 1'b0 || wen_o !== 1'b1 || dmem_req_o !== 1'b0) begin failures++; $display("FAIL rmid_alu wdata=%h stall=%b wen=%b req=%b", wdata_o, mem_not_ready_o, wen_o, dmem_req_o); end
        idle_cycle();
    endtask

    task automatic test_passthrough();
        set_idle();
        exception_i = 1; mcause_i = 64'd2; load_i = 1; funct3_i = 3'b011;
        aluout_i = 64'h1001; pc_i = 64'h8000_0010; wen_i = 1;
        #1;
        checks++; if (mem_not_ready_o !== 1'b0 || exception_o !== 1'b1 || mcause_o !== 64'd2) begin failures++; $display("FAIL pass_exc stall=%b exc=%b mcause=%0d", mem_not_ready_o, exception_o, mcause_o); end
        checks++; if (pc_o !== 64'h8000_0010 || wen_o !== 1'b1) begin failures++; $display("FAIL pass_pc pc=%h wen=%b", pc_o, wen_o); end
        @(posedge clock); #1;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL pass_req got=%b exp=0", dmem_req_o); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        int first;
        set_access(1, 0, 3'b000, 64'h1003, '0);
        run_access(1, 64'h0000_0000_8000_0000);
        first = first_req_cyc;
        set_access(1, 0, 3'b100, 64'h1001, '0);
        @(posedge clock); #1;
        run_access(1, 64'h0000_0000_0000_F100);
        checks++; if (first_req_cyc - first != 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=3", first_req_cyc - first); end
        checks++; if (wdata_o !== 64'hF1) begin failures++; $display("FAIL b2b_data got=%h exp=f1", wdata_o); end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_store_lanes();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_passthrough();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
